// File: rtl/mmio_controller_pkg.sv
// Shared MMIO types: store-port request layout, access widths, register map
// offsets and STATUS bit positions.
package mmio_controller_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2
    } mem_width_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        mem_width_t      width;
        logic [XLEN-1:0] value;
        logic            enable;
    } mem_write_control_t;

    localparam logic [XLEN-1:0] MMIO_UART_TX   = 32'h0000_0000;
    localparam logic [XLEN-1:0] MMIO_LED_BLUE  = 32'h0000_0004;
    localparam logic [XLEN-1:0] MMIO_LED_GREEN = 32'h0000_0008;
    localparam logic [XLEN-1:0] MMIO_STATUS    = 32'h0000_000C;
    localparam logic [XLEN-1:0] MMIO_TX_COUNT  = 32'h0000_0010;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_LEVEL_LSB = 8;

    function automatic logic [XLEN-1:0] pack_status(input logic empty,
                                                    input logic full,
                                                    input logic [7:0] level);
        logic [XLEN-1:0] word;
        word = {XLEN{1'b0}};
        word[STATUS_EMPTY_BIT] = empty;
        word[STATUS_FULL_BIT]  = full;
        word[STATUS_LEVEL_LSB +: 8] = level;
        return word;
    endfunction

endpackage

// File: rtl/mmio_controller_byte_fifo.sv
// Single-clock byte FIFO with occupancy counter; head holds the last popped
// byte while empty so the transmitter data lines stay stable.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     core_clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic [7:0]    last_head_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty     = (level_r == {(AW+1){1'b0}});
    assign full      = (level_r == (AW+1)'(DEPTH));
    assign level     = level_r;
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage array; contents are only meaningful between rd and wr pointers.
    always_ff @(posedge core_clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and the held head value.
    always_ff @(posedge core_clock) begin
        if (reset) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            level_r     <= {(AW+1){1'b0}};
            last_head_r <= 8'h00;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r    <= rd_ptr_r + AW'(1);
                last_head_r <= mem_r[rd_ptr_r];
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + (AW+1)'(1);
                2'b01:   level_r <= level_r - (AW+1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Head mux: live entry when data is queued, otherwise the last byte sent.
    always_comb begin
        if (empty) begin
            head = last_head_r;
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/mmio_controller.sv
// MMIO decode for UART TX FIFO, LEDs, STATUS and TX_COUNT; single-cycle
// completion except a byte store into a full FIFO, which stalls the hart.
module mmio_controller
    import mmio_controller_pkg::*;
#(
    parameter int              FIFO_DEPTH = 8,
    parameter logic [XLEN-1:0] BASE_ADDR  = 32'h0003_0000
) (
    input  logic               core_clock,
    input  logic               reset,
    input  mem_write_control_t mmio_control,
    output logic               mmio_write_complete,
    output logic [XLEN-1:0]    mmio_r_data,
    output logic [7:0]         serial_tx_data,
    output logic               serial_tx_data_available,
    input  logic               serial_tx_ready,
    output logic               led_blue_control,
    output logic               led_green_control
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] offset_s;
    logic            uart_byte_s;
    logic            push_s;
    logic            pop_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic [LW-1:0]   fifo_level_s;
    logic            led_blue_r;
    logic            led_green_r;
    logic [31:0]     tx_count_r;

    assign offset_s    = mmio_control.addr - BASE_ADDR;
    assign uart_byte_s = (offset_s == MMIO_UART_TX) && (mmio_control.width == WIDTH_BYTE);
    assign push_s      = mmio_control.enable && uart_byte_s && !fifo_full_s;
    assign pop_s       = serial_tx_ready && !fifo_empty_s;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .core_clock (core_clock),
        .reset      (reset),
        .push       (push_s),
        .push_data  (mmio_control.value[7:0]),
        .pop        (pop_s),
        .head       (serial_tx_data),
        .empty      (fifo_empty_s),
        .full       (fifo_full_s),
        .level      (fifo_level_s)
    );

    assign serial_tx_data_available = !fifo_empty_s;
    assign led_blue_control         = led_blue_r;
    assign led_green_control        = led_green_r;

    // Completion: only a byte store into a full FIFO is held off.
    always_comb begin
        if (!mmio_control.enable) begin
            mmio_write_complete = 1'b0;
        end else if (uart_byte_s) begin
            mmio_write_complete = !fifo_full_s;
        end else begin
            mmio_write_complete = 1'b1;
        end
    end

    // LED registers and the transmitted-byte counter.
    always_ff @(posedge core_clock) begin
        if (reset) begin
            led_blue_r  <= 1'b0;
            led_green_r <= 1'b0;
            tx_count_r  <= 32'd0;
        end else begin
            if (mmio_control.enable && (offset_s == MMIO_LED_BLUE)) begin
                led_blue_r <= (mmio_control.value != 32'd0);
            end
            if (mmio_control.enable && (offset_s == MMIO_LED_GREEN)) begin
                led_green_r <= (mmio_control.value != 32'd0);
            end
            if (pop_s) begin
                tx_count_r <= tx_count_r + 32'd1;
            end
        end
    end

    // Read mux, independent of enable.
    always_comb begin
        case (offset_s)
            MMIO_LED_BLUE:  mmio_r_data = {31'd0, led_blue_r};
            MMIO_LED_GREEN: mmio_r_data = {31'd0, led_green_r};
            MMIO_STATUS:    mmio_r_data = pack_status(fifo_empty_s, fifo_full_s, 8'(fifo_level_s));
            MMIO_TX_COUNT:  mmio_r_data = tx_count_r;
            default:        mmio_r_data = 32'd0;
        endcase
    end

endmodule
